// File: rtl/machine_mode_types_1_7_pkg.sv
// Shared priv-1.7 machine-mode CSR types: address map, counter widths and the
// decode used by the timer/counter block.
package machine_mode_types_1_7_pkg;

    typedef logic [11:0] csr_addr_t;
    typedef logic [31:0] word_t;
    typedef logic [31:0] mtime_t;
    typedef logic [31:0] mtimeh_t;
    typedef logic [31:0] mtimecmp_t;
    typedef logic [63:0] mcycle_t;
    typedef logic [63:0] minstret_t;

    localparam csr_addr_t CSR_MSTATUS  = 12'h300;
    localparam csr_addr_t CSR_MTIMECMP = 12'h321;
    localparam csr_addr_t CSR_MTIME    = 12'h701;
    localparam csr_addr_t CSR_MTIMEH   = 12'h741;
    localparam csr_addr_t CSR_CYCLE    = 12'hC00;
    localparam csr_addr_t CSR_TIME     = 12'hC01;
    localparam csr_addr_t CSR_INSTRET  = 12'hC02;
    localparam csr_addr_t CSR_CYCLEH   = 12'hC80;
    localparam csr_addr_t CSR_TIMEH    = 12'hC81;
    localparam csr_addr_t CSR_INSTRETH = 12'hC82;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_CYCLE,
        SEL_CYCLEH,
        SEL_INSTRET,
        SEL_INSTRETH,
        SEL_TIME,
        SEL_TIMEH,
        SEL_MTIME,
        SEL_MTIMEH,
        SEL_MTIMECMP
    } csr_sel_e;

    function automatic csr_sel_e csr_decode(input csr_addr_t a);
        csr_sel_e s;
        case (a)
            CSR_CYCLE:    s = SEL_CYCLE;
            CSR_CYCLEH:   s = SEL_CYCLEH;
            CSR_INSTRET:  s = SEL_INSTRET;
            CSR_INSTRETH: s = SEL_INSTRETH;
            CSR_TIME:     s = SEL_TIME;
            CSR_TIMEH:    s = SEL_TIMEH;
            CSR_MTIME:    s = SEL_MTIME;
            CSR_MTIMEH:   s = SEL_MTIMEH;
            CSR_MTIMECMP: s = SEL_MTIMECMP;
            default:      s = SEL_NONE;
        endcase
        return s;
    endfunction

    // User-level counter views are read-only; writes to them are dropped.
    function automatic logic csr_sel_is_ro(input csr_sel_e s);
        return s inside {SEL_CYCLE, SEL_CYCLEH, SEL_INSTRET, SEL_INSTRETH,
                         SEL_TIME, SEL_TIMEH};
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit CSR counter with independent half-word writes that override the
// increment (a low write suppresses the increment; a high write drops the carry).
module csr_counter64
    import machine_mode_types_1_7_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_inc,
    input  logic    i_wr_lo,
    input  logic    i_wr_hi,
    input  word_t   i_wdata,
    output mcycle_t o_count
);

    mcycle_t r_count;
    mcycle_t w_inc_val;
    mcycle_t w_next;

    always_comb begin
        w_inc_val = i_inc ? r_count + 64'd1 : r_count;
        w_next    = w_inc_val;
        if (i_wr_lo) begin
            w_next = {r_count[63:32], i_wdata};
        end
        if (i_wr_hi) begin
            w_next[63:32] = i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/machine_timer_counters.sv
// Timer/counter CSRs (cycle, instret, mtime, mtimecmp) and the mtip timer
// interrupt, decoded and read back for the machine-mode CSR file.
module machine_timer_counters
    import machine_mode_types_1_7_pkg::*;
#(
    parameter int unsigned TIME_PRESCALE = 1
)
(
    input  logic      CLK,
    input  logic      nRST,
    input  csr_addr_t csr_addr,
    input  logic      csr_wen,
    input  word_t     csr_wdata,
    input  logic      inst_ret,
    output logic      csr_hit,
    output word_t     csr_rdata,
    output logic      csr_ro_fault,
    output logic      mtip
);

    localparam int unsigned PS_W = (TIME_PRESCALE > 1) ? $clog2(TIME_PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TIME_PRESCALE - 1);

    csr_sel_e        w_sel;
    logic            w_wr_mtime;
    logic            w_wr_mtimeh;
    logic            w_wr_mtimecmp;
    logic            w_tick;
    logic            w_match;
    logic [PS_W-1:0] r_ps;
    mtimecmp_t       r_mtimecmp;
    logic            r_mtip;
    mcycle_t         w_mcycle;
    minstret_t       w_minstret;
    logic [63:0]     w_mtime;

    assign w_sel         = csr_decode(csr_addr);
    assign csr_hit       = (w_sel != SEL_NONE);
    assign csr_ro_fault  = csr_wen & csr_sel_is_ro(w_sel);
    assign w_wr_mtime    = csr_wen & (w_sel == SEL_MTIME);
    assign w_wr_mtimeh   = csr_wen & (w_sel == SEL_MTIMEH);
    assign w_wr_mtimecmp = csr_wen & (w_sel == SEL_MTIMECMP);
    assign w_tick        = (r_ps == PS_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ps <= '0;
        end else if (w_wr_mtime || w_tick) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + PS_W'(1);
        end
    end

    csr_counter64 u_mcycle (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_inc   (1'b1),
        .i_wr_lo (1'b0),
        .i_wr_hi (1'b0),
        .i_wdata (csr_wdata),
        .o_count (w_mcycle)
    );

    csr_counter64 u_minstret (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_inc   (inst_ret),
        .i_wr_lo (1'b0),
        .i_wr_hi (1'b0),
        .i_wdata (csr_wdata),
        .o_count (w_minstret)
    );

    csr_counter64 u_mtime (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_inc   (w_tick),
        .i_wr_lo (w_wr_mtime),
        .i_wr_hi (w_wr_mtimeh),
        .i_wdata (csr_wdata),
        .o_count (w_mtime)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mtimecmp <= '0;
        end else if (w_wr_mtimecmp) begin
            r_mtimecmp <= csr_wdata;
        end
    end

    // Compare against the value mtime[31:0] is about to take, so mtip rises on
    // the same edge that TIME reaches mtimecmp; mtime writes skip the compare.
    assign w_match = ((w_mtime[31:0] + 32'd1) == r_mtimecmp);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mtip <= 1'b0;
        end else if (w_wr_mtimecmp) begin
            r_mtip <= 1'b0;
        end else if (w_tick && !w_wr_mtime && !w_wr_mtimeh && w_match) begin
            r_mtip <= 1'b1;
        end
    end

    assign mtip = r_mtip;

    always_comb begin
        csr_rdata = '0;
        case (w_sel)
            SEL_CYCLE:    csr_rdata = w_mcycle[31:0];
            SEL_CYCLEH:   csr_rdata = w_mcycle[63:32];
            SEL_INSTRET:  csr_rdata = w_minstret[31:0];
            SEL_INSTRETH: csr_rdata = w_minstret[63:32];
            SEL_TIME:     csr_rdata = w_mtime[31:0];
            SEL_TIMEH:    csr_rdata = w_mtime[63:32];
            SEL_MTIME:    csr_rdata = w_mtime[31:0];
            SEL_MTIMEH:   csr_rdata = w_mtime[63:32];
            SEL_MTIMECMP: csr_rdata = r_mtimecmp;
            default:      csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_machine_timer_counters.sv
// Bench for machine_timer_counters: two instances (prescale 1 and 4) share
// stimulus and are compared against a per-instance behavioural model.
module tb_machine_timer_counters;
    import machine_mode_types_1_7_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    csr_addr_t csr_addr = CSR_MSTATUS;
    logic      csr_wen = 1'b0;
    word_t     csr_wdata = '0;
    logic      inst_ret = 1'b0;

    logic  hit1, hit4, flt1, flt4, mtip1, mtip4;
    word_t rd1, rd4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    machine_timer_counters #(.TIME_PRESCALE(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .csr_addr(csr_addr), .csr_wen(csr_wen),
        .csr_wdata(csr_wdata), .inst_ret(inst_ret), .csr_hit(hit1),
        .csr_rdata(rd1), .csr_ro_fault(flt1), .mtip(mtip1)
    );

    machine_timer_counters #(.TIME_PRESCALE(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .csr_addr(csr_addr), .csr_wen(csr_wen),
        .csr_wdata(csr_wdata), .inst_ret(inst_ret), .csr_hit(hit4),
        .csr_rdata(rd4), .csr_ro_fault(flt4), .mtip(mtip4)
    );

    // ---------------- behavioural model ----------------
    logic [63:0] m_cyc = '0;
    logic [63:0] m_ins = '0;
    logic [63:0] m_time [2] = '{64'd0, 64'd0};
    logic [31:0] m_cmp  [2] = '{32'd0, 32'd0};
    int unsigned m_ps   [2] = '{0, 0};
    logic        m_mtip [2] = '{1'b0, 1'b0};

    function automatic int unsigned ps_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic m_tick(input int k);
        return m_ps[k] == ps_of(k) - 1;
    endfunction

    function automatic logic [63:0] m_adv(input int k);
        return m_tick(k) ? m_time[k] + 64'd1 : m_time[k];
    endfunction

    function automatic logic m_owned(input csr_addr_t a);
        return a inside {CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH, CSR_TIME,
                         CSR_TIMEH, CSR_MTIME, CSR_MTIMEH, CSR_MTIMECMP};
    endfunction

    function automatic logic m_ro(input csr_addr_t a);
        return a inside {CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH, CSR_TIME, CSR_TIMEH};
    endfunction

    function automatic logic [31:0] m_rd(input int k, input csr_addr_t a);
        case (a)
            CSR_CYCLE:               return m_cyc[31:0];
            CSR_CYCLEH:              return m_cyc[63:32];
            CSR_INSTRET:             return m_ins[31:0];
            CSR_INSTRETH:            return m_ins[63:32];
            CSR_TIME, CSR_MTIME:     return m_time[k][31:0];
            CSR_TIMEH, CSR_MTIMEH:   return m_time[k][63:32];
            CSR_MTIMECMP:            return m_cmp[k];
            default:                 return 32'h0;
        endcase
    endfunction

    logic t_wl, t_wh, t_wc;
    assign t_wl = csr_wen && (csr_addr == CSR_MTIME);
    assign t_wh = csr_wen && (csr_addr == CSR_MTIMEH);
    assign t_wc = csr_wen && (csr_addr == CSR_MTIMECMP);

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_cyc <= '0;
            m_ins <= '0;
            for (int k = 0; k < 2; k++) begin
                m_time[k] <= '0;
                m_cmp[k]  <= '0;
                m_ps[k]   <= 0;
                m_mtip[k] <= 1'b0;
            end
        end else begin
            m_cyc <= m_cyc + 64'd1;
            if (inst_ret) m_ins <= m_ins + 64'd1;
            for (int k = 0; k < 2; k++) begin
                if (t_wl) begin
                    m_time[k] <= {m_time[k][63:32], csr_wdata};
                    m_ps[k]   <= 0;
                end else begin
                    m_ps[k]   <= m_tick(k) ? 0 : m_ps[k] + 1;
                    m_time[k] <= t_wh ? {csr_wdata, m_adv(k)[31:0]} : m_adv(k);
                end
                if (t_wc) begin
                    m_cmp[k]  <= csr_wdata;
                    m_mtip[k] <= 1'b0;
                end else if (m_tick(k) && !t_wl && !t_wh &&
                             (m_time[k][31:0] + 32'd1 == m_cmp[k])) begin
                    m_mtip[k] <= 1'b1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic rd_chk(input string nm, input csr_addr_t a,
                          input logic [31:0] e1, input logic [31:0] e4);
        csr_addr = a;
        #1;
        chk({nm, "_p1"}, rd1, e1);
        chk({nm, "_p4"}, rd4, e4);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        chk("bg_hit_p1",   hit1,  m_owned(csr_addr));
        chk("bg_hit_p4",   hit4,  m_owned(csr_addr));
        chk("bg_fault_p1", flt1,  csr_wen && m_ro(csr_addr));
        chk("bg_fault_p4", flt4,  csr_wen && m_ro(csr_addr));
        chk("bg_rdata_p1", rd1,   m_rd(0, csr_addr));
        chk("bg_rdata_p4", rd4,   m_rd(1, csr_addr));
        chk("bg_mtip_p1",  mtip1, m_mtip[0]);
        chk("bg_mtip_p4",  mtip4, m_mtip[1]);
    end

    typedef struct packed {
        csr_addr_t addr;
        logic      wen;
        logic      exp_hit;
        logic      exp_fault;
    } dec_vec_t;

    dec_vec_t  tbl [13];
    csr_addr_t rnd_addrs [10];
    logic [31:0] exp_cyc;
    logic [31:0] cmp_val;
    int unsigned inst_pat [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{CSR_CYCLE,    1'b1, 1'b1, 1'b1};
        tbl[1]  = '{CSR_CYCLEH,   1'b1, 1'b1, 1'b1};
        tbl[2]  = '{CSR_INSTRET,  1'b1, 1'b1, 1'b1};
        tbl[3]  = '{CSR_INSTRETH, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{CSR_TIME,     1'b1, 1'b1, 1'b1};
        tbl[5]  = '{CSR_TIMEH,    1'b1, 1'b1, 1'b1};
        tbl[6]  = '{CSR_CYCLE,    1'b0, 1'b1, 1'b0};
        tbl[7]  = '{CSR_MTIME,    1'b0, 1'b1, 1'b0};
        tbl[8]  = '{CSR_MTIMEH,   1'b0, 1'b1, 1'b0};
        tbl[9]  = '{CSR_MTIMECMP, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{CSR_MSTATUS,  1'b1, 1'b0, 1'b0};
        tbl[11] = '{12'hC03,      1'b1, 1'b0, 1'b0};
        tbl[12] = '{12'h305,      1'b0, 1'b0, 1'b0};
        rnd_addrs = '{CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_TIME, CSR_TIMEH,
                      CSR_MTIME, CSR_MTIMEH, CSR_MTIMECMP, CSR_MSTATUS, 12'hC03};
        inst_pat = '{1, 0, 1, 1, 0};

        // Reset, then 10 idle cycles
        step();
        step();
        nRST = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        rd_chk("idle_cycle", CSR_CYCLE, 32'd10, 32'd10);
        rd_chk("idle_time", CSR_TIME, 32'd10, 32'd2);
        rd_chk("idle_instret", CSR_INSTRET, 32'd0, 32'd0);
        chk("idle_mtip_p1", mtip1, 1'b0);

        // inst_ret on 3 of 5 cycles
        foreach (inst_pat[i]) begin
            inst_ret = inst_pat[i][0];
            step();
        end
        inst_ret = 1'b0;
        rd_chk("instret3", CSR_INSTRET, 32'd3, 32'd3);

        // MTIME low-half wrap into TIMEH
        csr_addr = CSR_MTIME; csr_wen = 1'b1; csr_wdata = 32'hFFFF_FFFF;
        step();
        csr_wen = 1'b0;
        rd_chk("wrap_time0", CSR_TIME, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_chk("wrap_timeh0", CSR_TIMEH, 32'd0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            rd_chk("wrap_time", CSR_TIME, 32'(k - 1), (k < 4) ? 32'hFFFF_FFFF : 32'd0);
            rd_chk("wrap_timeh", CSR_TIMEH, 32'd1, (k < 4) ? 32'd0 : 32'd1);
            chk("wrap_mtip_p1", mtip1, 1'b1);
            chk("wrap_mtip_p4", mtip4, k == 4);
        end

        // MTIMECMP=20 then MTIME=15; mtip rises as TIME reaches 20
        csr_addr = CSR_MTIMECMP; csr_wen = 1'b1; csr_wdata = 32'd20;
        step();
        chk("cmpwr_mtip_p1", mtip1, 1'b0);
        chk("cmpwr_mtip_p4", mtip4, 1'b0);
        csr_addr = CSR_MTIME; csr_wdata = 32'd15;
        step();
        csr_wen = 1'b0;
        rd_chk("cmp_time15", CSR_TIME, 32'd15, 32'd15);
        for (int k = 1; k <= 7; k++) begin
            step();
            rd_chk("cmp_time", CSR_TIME, 32'(15 + k), (k < 4) ? 32'd15 : 32'd16);
            chk("cmp_mtip_p1", mtip1, k >= 5);
            chk("cmp_mtip_p4", mtip4, 1'b0);
        end
        csr_addr = CSR_MTIMECMP; csr_wen = 1'b1; csr_wdata = 32'd100;
        step();
        csr_wen = 1'b0;
        chk("cmp100_mtip_p1", mtip1, 1'b0);
        rd_chk("cmp100_rd", CSR_MTIMECMP, 32'd100, 32'd100);

        // MTIME=7 mid-count: prescaled increment 4 cycles after the write
        step();
        step();
        csr_addr = CSR_MTIME; csr_wen = 1'b1; csr_wdata = 32'd7;
        step();
        csr_wen = 1'b0;
        rd_chk("ps_time7", CSR_TIME, 32'd7, 32'd7);
        for (int k = 1; k <= 4; k++) begin
            step();
            rd_chk("ps_time", CSR_TIME, 32'(7 + k), (k < 4) ? 32'd7 : 32'd8);
        end

        // MTIMEH write drops a same-cycle carry from the low half
        csr_addr = CSR_MTIME; csr_wen = 1'b1; csr_wdata = 32'hFFFF_FFFF;
        step();
        csr_addr = CSR_MTIMEH; csr_wdata = 32'h0000_000A;
        step();
        csr_wen = 1'b0;
        rd_chk("hiwr_time", CSR_TIME, 32'd0, 32'hFFFF_FFFF);
        rd_chk("hiwr_timeh", CSR_TIMEH, 32'hA, 32'hA);

        // Decode table
        foreach (tbl[i]) begin
            step();
            csr_addr = tbl[i].addr; csr_wen = tbl[i].wen; csr_wdata = 32'd5;
            #1;
            chk($sformatf("tbl%0d_hit", i), hit1, tbl[i].exp_hit);
            chk($sformatf("tbl%0d_fault", i), flt1, tbl[i].exp_fault);
            chk($sformatf("tbl%0d_rdata", i), rd1, m_rd(0, tbl[i].addr));
            if (!tbl[i].exp_hit) chk($sformatf("tbl%0d_zero", i), rd4, 32'h0);
        end
        csr_wen = 1'b0;

        // Write to CYCLE is faulted and dropped
        step();
        csr_addr = CSR_CYCLE; csr_wen = 1'b1; csr_wdata = 32'd5;
        exp_cyc = m_cyc[31:0] + 32'd1;
        #1;
        chk("cycwr_fault", flt1, 1'b1);
        step();
        csr_wen = 1'b0;
        rd_chk("cycwr_cycle", CSR_CYCLE, exp_cyc, exp_cyc);

        // Randomised traffic, checked every cycle by the model
        repeat (400) begin
            step();
            inst_ret = 1'($urandom % 2);
            csr_addr = rnd_addrs[$urandom % 10];
            csr_wen  = ($urandom % 5) == 0;
            case (csr_addr)
                CSR_MTIMECMP: csr_wdata = m_time[0][31:0] + $urandom_range(1, 6);
                CSR_MTIME:    csr_wdata = ($urandom % 2 == 1) ?
                                          32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom;
                default:      csr_wdata = $urandom;
            endcase
        end
        csr_wen = 1'b0;
        inst_ret = 1'b0;

        // Reset while mtip is set and counters are nonzero
        step();
        cmp_val = m_time[0][31:0] + 32'd3;
        csr_addr = CSR_MTIMECMP; csr_wen = 1'b1; csr_wdata = cmp_val;
        step();
        csr_wen = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("prerst_mtip_p1", mtip1, 1'b1);
        step();
        nRST = 1'b0;
        #1;
        chk("rst_mtip_p1", mtip1, 1'b0);
        chk("rst_mtip_p4", mtip4, 1'b0);
        rd_chk("rst_cycle", CSR_CYCLE, 32'd0, 32'd0);
        rd_chk("rst_cycleh", CSR_CYCLEH, 32'd0, 32'd0);
        rd_chk("rst_instret", CSR_INSTRET, 32'd0, 32'd0);
        rd_chk("rst_instreth", CSR_INSTRETH, 32'd0, 32'd0);
        rd_chk("rst_time", CSR_TIME, 32'd0, 32'd0);
        rd_chk("rst_timeh", CSR_TIMEH, 32'd0, 32'd0);
        rd_chk("rst_mtimecmp", CSR_MTIMECMP, 32'd0, 32'd0);
        step();
        nRST = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        chk("postrst_mtip_p1", mtip1, 1'b0);
        chk("postrst_mtip_p4", mtip4, 1'b0);
        rd_chk("postrst_time", CSR_TIME, 32'd20, 32'd5);
        rd_chk("postrst_cycle", CSR_CYCLE, 32'd20, 32'd20);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
